// File: rtl/asynch_fifo_pkg.sv
// ============================================================================
// Module      : asynch_fifo_pkg
// Description : Shared types and helpers for the asynchronous FIFO controllers.
//               Includes Gray/binary conversion and the read-side FWFT state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package asynch_fifo_pkg;

    localparam int c_RD_FSM_W = 2;

    typedef enum logic [c_RD_FSM_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } rd_state_t;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int PTR_W(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/asynch_fifo_rd_ctrl_if.sv
// ============================================================================
// Module      : asynch_fifo_rd_ctrl_if
// Description : Read-domain bus of the asynchronous FIFO. The master side is
//               the read controller; the slave side is the consumer/RAM.
//               rvalid exists only when ASYNCH_FIFO_RD_FWFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface asynch_fifo_rd_ctrl_if
    import asynch_fifo_pkg::*;
#(
    parameter int ADDR_W = 3
);
    localparam int c_PTR_W = PTR_W(ADDR_W);

    logic               rinc;
    logic [c_PTR_W-1:0] rq2_gray_wptr;
    logic [ADDR_W-1:0]  raddr;
    logic               rmem_en;
    logic [c_PTR_W-1:0] gray_rd_ptr;
    logic               rempty;
    logic               raempty;
    logic [c_PTR_W-1:0] rcount;
    logic               runderflow;

`ifdef ASYNCH_FIFO_RD_FWFT_EN
    logic               rvalid;

    modport master (
        input  rinc, rq2_gray_wptr,
        output raddr, rmem_en, gray_rd_ptr, rempty, raempty, rcount,
               runderflow, rvalid
    );

    modport slave (
        output rinc, rq2_gray_wptr,
        input  raddr, rmem_en, gray_rd_ptr, rempty, raempty, rcount,
               runderflow, rvalid
    );
`else
    modport master (
        input  rinc, rq2_gray_wptr,
        output raddr, rmem_en, gray_rd_ptr, rempty, raempty, rcount,
               runderflow
    );

    modport slave (
        output rinc, rq2_gray_wptr,
        input  raddr, rmem_en, gray_rd_ptr, rempty, raempty, rcount,
               runderflow
    );
`endif

endinterface

`default_nettype wire

// File: rtl/asynch_fifo_gray2bin.sv
// ============================================================================
// Module      : asynch_fifo_gray2bin
// Description : Combinational Gray-to-binary converter (XOR prefix from MSB).
//               Shared by the read- and write-side controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asynch_fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_gray,
    output logic      [WIDTH-1:0] o_bin
);

    // Each binary bit is the parity of all Gray bits at or above it.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign o_bin[i] = ^i_gray[WIDTH-1:i];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/asynch_fifo_rd_ctrl.sv
// ============================================================================
// Module      : asynch_fifo_rd_ctrl
// Description : Read-domain controller of the asynchronous FIFO: read
//               pointers, RAM read port control, empty/almost-empty flags,
//               fill count and sticky underflow. Defining
//               ASYNCH_FIFO_RD_FWFT_EN selects first-word-fall-through mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asynch_fifo_rd_ctrl
    import asynch_fifo_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int AE_THRESH = 1
) (
    input  wire                   rclk,
    input  wire                   rrst,
    asynch_fifo_rd_ctrl_if.master bus
);

    localparam int                 c_PTR_W = PTR_W(ADDR_W);
    localparam logic [c_PTR_W-1:0] c_AE    = c_PTR_W'(AE_THRESH);

    logic [c_PTR_W-1:0] r_bin;
    logic [c_PTR_W-1:0] r_gray;
    logic [c_PTR_W-1:0] r_count;
    logic               r_empty_int;
    logic               r_aempty;
    logic               r_underflow;

    logic [c_PTR_W-1:0] w_wbin;
    logic [c_PTR_W-1:0] w_rnext;
    logic [c_PTR_W-1:0] w_rgnext;
    logic [c_PTR_W-1:0] w_count;
    logic               w_pop;
    logic               w_uf_evt;

    asynch_fifo_gray2bin #(
        .WIDTH (c_PTR_W)
    ) u_wptr_g2b (
        .i_gray (bus.rq2_gray_wptr),
        .o_bin  (w_wbin)
    );

    assign w_rnext  = r_bin + {{(c_PTR_W-1){1'b0}}, w_pop};
    assign w_rgnext = w_rnext ^ (w_rnext >> 1);
    assign w_count  = w_wbin - w_rnext;

`ifdef ASYNCH_FIFO_RD_FWFT_EN
    rd_state_t r_state;
    logic      r_valid;
    logic      w_fetch;

    // Prefetch whenever the output holding slot is free or being consumed.
    assign w_fetch  = ~r_empty_int & (~r_valid | bus.rinc);
    assign w_pop    = w_fetch;
    assign w_uf_evt = bus.rinc & ~r_valid;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_fetch | (r_valid & ~bus.rinc);
            case (r_state)
                ST_IDLE: begin
                    if (w_fetch) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH, ST_VALID: begin
                    if (bus.rinc) begin
                        r_state <= w_fetch ? ST_FETCH : ST_IDLE;
                    end else begin
                        r_state <= ST_VALID;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rempty = ~r_valid;
    assign bus.rvalid = r_valid;
`else
    assign w_pop      = bus.rinc & ~r_empty_int;
    assign w_uf_evt   = bus.rinc & r_empty_int;
    assign bus.rempty = r_empty_int;
`endif

    // Flags and count use the look-ahead pointer so a pop and a
    // synchronised write-pointer change in the same cycle both land.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin       <= '0;
            r_gray      <= '0;
            r_count     <= '0;
            r_empty_int <= 1'b1;
            r_aempty    <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_bin       <= w_rnext;
            r_gray      <= w_rgnext;
            r_count     <= w_count;
            r_empty_int <= (w_rgnext == bus.rq2_gray_wptr);
            r_aempty    <= (w_count <= c_AE);
            r_underflow <= r_underflow | w_uf_evt;
        end
    end

    assign bus.raddr       = r_bin[ADDR_W-1:0];
    assign bus.rmem_en     = w_pop;
    assign bus.gray_rd_ptr = r_gray;
    assign bus.rcount      = r_count;
    assign bus.raempty     = r_aempty;
    assign bus.runderflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_asynch_fifo_rd_ctrl.sv
// ============================================================================
// Module      : tb_asynch_fifo_rd_ctrl
// Description : Self-checking bench for asynch_fifo_rd_ctrl (ADDR_W=3,
//               AE_THRESH=1). Covers FWFT mode when ASYNCH_FIFO_RD_FWFT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asynch_fifo_rd_ctrl;

    localparam int ADDR_W    = 3;
    localparam int AE_THRESH = 1;
    localparam int DEPTH     = 8;
    localparam int PMOD      = 16;

    logic rclk = 1'b0;
    logic rrst;

    always #5 rclk = ~rclk;

    asynch_fifo_rd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    asynch_fifo_rd_ctrl #(
        .ADDR_W    (ADDR_W),
        .AE_THRESH (AE_THRESH)
    ) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference view: read pointer and write pointer as plain integers.
    int m_wp    = 0;
    int m_rbin  = 0;
    int m_count = 0;
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_uf    = 1'b0;

    int exp_g [8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit inc, input bit rst_v, input int wp);
        bus.rinc          = inc;
        rrst              = rst_v;
        m_wp              = wp;
        bus.rq2_gray_wptr = 4'(gray(wp % PMOD));
        @(posedge rclk);
        if (rst_v) begin
            m_rbin  = 0;
            m_count = 0;
            m_empty = 1'b1;
            m_ae    = 1'b1;
            m_uf    = 1'b0;
        end else begin
            if (inc && m_empty) m_uf = 1'b1;
            if (inc && !m_empty) m_rbin = (m_rbin + 1) % PMOD;
            m_count = ((wp % PMOD) - m_rbin + PMOD) % PMOD;
            m_empty = (m_count == 0);
            m_ae    = (m_count <= AE_THRESH);
        end
        #1;
    endtask

`ifndef ASYNCH_FIFO_RD_FWFT_EN
    always @(negedge rclk) begin
        if (chk_en) begin
            chk("raddr",       int'(bus.raddr),       m_rbin % DEPTH);
            chk("gray_rd_ptr", int'(bus.gray_rd_ptr), gray(m_rbin));
            chk("rempty",      int'(bus.rempty),      int'(m_empty));
            chk("raempty",     int'(bus.raempty),     int'(m_ae));
            chk("rcount",      int'(bus.rcount),      m_count);
            chk("runderflow",  int'(bus.runderflow),  int'(m_uf));
            chk("rmem_en",     int'(bus.rmem_en),     int'(bus.rinc && !m_empty));
        end
    end
`endif

    initial begin
        int wp;
        rrst              = 1'b1;
        bus.rinc          = 1'b1;
        bus.rq2_gray_wptr = 4'b0110;

`ifndef ASYNCH_FIFO_RD_FWFT_EN
        // Reset overrides a pop request and a non-empty write pointer.
        cyc(1'b1, 1'b1, 4);
        chk_en = 1'b1;
        chk("rst_rempty",  int'(bus.rempty),      1);
        chk("rst_raempty", int'(bus.raempty),     1);
        chk("rst_rcount",  int'(bus.rcount),      0);
        chk("rst_gray",    int'(bus.gray_rd_ptr), 0);
        chk("rst_raddr",   int'(bus.raddr),       0);
        chk("rst_uf",      int'(bus.runderflow),  0);
        cyc(1'b1, 1'b1, 4);
        chk("rst_hold_gray", int'(bus.gray_rd_ptr), 0);
        cyc(1'b0, 1'b1, 0);

        // Fill with 8 words, then drain them.
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, i);
        chk("fill_rcount",  int'(bus.rcount),  8);
        chk("fill_rempty",  int'(bus.rempty),  0);
        chk("fill_raempty", int'(bus.raempty), 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_raddr", int'(bus.raddr), i);
            cyc(1'b1, 1'b0, 8);
            chk("drain_gray", int'(bus.gray_rd_ptr), exp_g[i]);
            if (i == 5) chk("drain_ae_cnt2", int'(bus.raempty), 0);
            if (i == 6) chk("drain_ae_cnt1", int'(bus.raempty), 1);
        end
        chk("drain_rempty", int'(bus.rempty), 1);
        chk("drain_rcount", int'(bus.rcount), 0);

        // Underflow: pointer must not move, flag must stick.
        cyc(1'b1, 1'b0, 8);
        chk("uf_set",   int'(bus.runderflow),  1);
        chk("uf_gray",  int'(bus.gray_rd_ptr), 12);
        chk("uf_raddr", int'(bus.raddr),       0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8);
        chk("uf_sticky", int'(bus.runderflow), 1);

        // Pop coinciding with write pointer advancing from 1 to 2 words.
        cyc(1'b0, 1'b0, 9);
        chk("sim_pre_rcount", int'(bus.rcount), 1);
        cyc(1'b1, 1'b0, 10);
        chk("sim_rcount", int'(bus.rcount), 1);
        chk("sim_rempty", int'(bus.rempty), 0);

        cyc(1'b0, 1'b1, 0);
        chk("uf_cleared", int'(bus.runderflow), 0);

        // Wrap-around through 40 write/pop pairs.
        wp = 0;
        for (int k = 0; k < 40; k++) begin
            wp++;
            cyc(1'b0, 1'b0, wp);
            cyc(1'b1, 1'b0, wp);
            if (wp % PMOD == 15) chk("wrap_gray_15", int'(bus.gray_rd_ptr), 8);
            if (wp % PMOD == 0)  chk("wrap_gray_0",  int'(bus.gray_rd_ptr), 0);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                wp = 0;
                cyc(1'($urandom_range(0, 1)), 1'b1, wp);
            end else begin
                if ($urandom_range(0, 1) == 1 &&
                    (((wp % PMOD) - m_rbin + PMOD) % PMOD) < DEPTH) begin
                    wp++;
                end
                cyc(($urandom_range(0, 2) != 0), 1'b0, wp);
            end
        end
        chk_en = 1'b0;
`else
        cyc(1'b0, 1'b1, 0);
        cyc(1'b0, 1'b0, 0);
        chk("fw_rst_rvalid", int'(bus.rvalid),  0);
        chk("fw_rst_rempty", int'(bus.rempty),  1);
        chk("fw_rst_memen",  int'(bus.rmem_en), 0);

        // One word written with no read request.
        cyc(1'b0, 1'b0, 1);
        chk("fw_fetch_memen",  int'(bus.rmem_en), 1);
        chk("fw_fetch_rvalid", int'(bus.rvalid),  0);
        chk("fw_fetch_rcount", int'(bus.rcount),  1);
        cyc(1'b0, 1'b0, 1);
        chk("fw_memen_off", int'(bus.rmem_en), 0);
        chk("fw_rvalid",    int'(bus.rvalid),  1);
        chk("fw_rempty",    int'(bus.rempty),  0);
        chk("fw_rcount",    int'(bus.rcount),  0);
        chk("fw_raddr",     int'(bus.raddr),   1);
        cyc(1'b0, 1'b0, 1);
        chk("fw_hold_rvalid", int'(bus.rvalid),  1);
        chk("fw_hold_memen",  int'(bus.rmem_en), 0);
        cyc(1'b1, 1'b0, 1);
        chk("fw_pop_rvalid", int'(bus.rvalid),     0);
        chk("fw_pop_rempty", int'(bus.rempty),     1);
        chk("fw_pop_uf",     int'(bus.runderflow), 0);
        cyc(1'b1, 1'b0, 1);
        chk("fw_uf", int'(bus.runderflow), 1);
        chk("fw_uf_raddr", int'(bus.raddr), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
